// File: rtl/fetch_queue_pkg.sv
// Shared types for the rv32imc fetch front end: queue entry layout and reset PC.
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of imem, decode and redirect signals around the fetch queue.
interface fetch_queue_if;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;

    modport master (
        input  i_redirect, i_redirect_pc, imem_rdata, imem_resp, i_ready,
        output imem_addr, imem_rmask, o_valid, o_inst, o_pc
    );

    modport slave (
        output i_redirect, i_redirect_pc, imem_rdata, imem_resp, i_ready,
        input  imem_addr, imem_rmask, o_valid, o_inst, o_pc
    );
endinterface

// File: rtl/fetch_queue_chk.sv
// Invariant checks for the fetch queue credit and discard counters.
module fetch_queue_chk #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int CW           = 3,
    parameter int IW           = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_resp,
    input logic [CW-1:0] count,
    input logic [IW-1:0] inflight,
    input logic [IW-1:0] discard
);

    a_credit: assert property (@(posedge clk) disable iff (rst)
        (32'(count) + 32'(inflight)) <= 32'(DEPTH));

    a_inflight_max: assert property (@(posedge clk) disable iff (rst)
        32'(inflight) <= 32'(MAX_INFLIGHT));

    a_discard: assert property (@(posedge clk) disable iff (rst)
        discard <= inflight);

    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp && (inflight == {IW{1'b0}})));

endmodule

// File: rtl/fetch_queue_fifo.sv
// Power-of-two circular buffer of fetch entries with push/pop/clear and occupancy count.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against occupancy; clear overrides both.
    always_comb begin
        do_push_s = push && !full && !clear;
        do_pop_s  = pop && !empty && !clear;
    end

    // Pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_push_s) tail_r <= tail_r + AW'(1);
            if (do_pop_s)  head_r <= head_r + AW'(1);
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[tail_r] <= push_data;
    end

    assign head  = mem_r[head_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: credit-based imem issue, in-order response queue, redirect flush.
// Optional FETCHQ_BYPASS_EN lets a response reach decode in the same cycle when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          MAX_INFLIGHT = 2,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [IW-1:0] inflight_r;
    logic [IW-1:0] discard_r;

    logic [31:0]   occ_s;
    logic          resp_ok_s;
    logic          issue_s;
    logic          keep_s;
    logic          push_s;
    logic          pop_s;
    logic          bypass_s;
    fetch_entry_t  push_data_s;
    fetch_entry_t  head_s;
    logic [CW-1:0] count_s;
    logic          full_s;
    logic          empty_s;

    // Issue credit, response qualification and decode-side view of the queue.
    always_comb begin
        occ_s       = 32'(count_s) + 32'(inflight_r);
        resp_ok_s   = bus.imem_resp && (inflight_r != {IW{1'b0}});
        issue_s     = !rst && !bus.i_redirect
                      && (32'(inflight_r) < 32'(MAX_INFLIGHT))
                      && (occ_s < 32'(DEPTH));
        keep_s      = resp_ok_s && (discard_r == {IW{1'b0}}) && !bus.i_redirect;
        push_data_s = '{inst: bus.imem_rdata, pc: resp_pc_r};
        pop_s       = !empty_s && bus.i_ready && !bus.i_redirect;
`ifdef FETCHQ_BYPASS_EN
        bypass_s    = keep_s && empty_s;
        push_s      = keep_s && !(bypass_s && bus.i_ready);
        if (bypass_s) begin
            bus.o_valid = 1'b1;
            bus.o_inst  = bus.imem_rdata;
            bus.o_pc    = resp_pc_r;
        end else begin
            bus.o_valid = !empty_s;
            bus.o_inst  = head_s.inst;
            bus.o_pc    = head_s.pc;
        end
`else
        bypass_s    = 1'b0;
        push_s      = keep_s;
        bus.o_valid = !empty_s;
        bus.o_inst  = head_s.inst;
        bus.o_pc    = head_s.pc;
`endif
        bus.imem_rmask = issue_s ? 4'hf : 4'h0;
        bus.imem_addr  = fetch_pc_r;
    end

    // Fetch/response PCs and outstanding-request bookkeeping; redirect wins over everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= word_align(RESET_PC);
            resp_pc_r  <= word_align(RESET_PC);
            inflight_r <= {IW{1'b0}};
            discard_r  <= {IW{1'b0}};
        end else if (bus.i_redirect) begin
            fetch_pc_r <= word_align(bus.i_redirect_pc);
            resp_pc_r  <= word_align(bus.i_redirect_pc);
            inflight_r <= inflight_r - IW'(resp_ok_s);
            discard_r  <= inflight_r - IW'(resp_ok_s);
        end else begin
            if (issue_s) fetch_pc_r <= fetch_pc_r + 32'd4;
            if (keep_s)  resp_pc_r  <= resp_pc_r + 32'd4;
            inflight_r <= inflight_r + IW'(issue_s) - IW'(resp_ok_s);
            if (resp_ok_s && (discard_r != {IW{1'b0}})) discard_r <= discard_r - IW'(1);
        end
    end

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.i_redirect),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    fetch_queue_chk #(
        .DEPTH(DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT), .CW(CW), .IW(IW)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .imem_resp (bus.imem_resp),
        .count     (count_s),
        .inflight  (inflight_r),
        .discard   (discard_r)
    );

endmodule
